// File: rtl/ahb_mtx_input_stage_if.sv
// ahb_mtx_input_stage_if
//   Bus bundle for one matrix input stage.
//   S-side: AHB-Lite address-phase signals from the master and the
//           HREADYOUTS/HRESPS response returned to it.
//   M-side: address-phase signals presented to the output stages,
//           req_port, and the grant/data-phase feedback from them
//           (addr_in_phase, data_in_phase, HREADYOUTM, HRESPM).
//   Modports: slave = the input stage itself, master = whatever drives it.
interface ahb_mtx_input_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic                  HRESPS;

  logic [ADDR_WIDTH-1:0] HADDRM;
  logic [1:0]            HTRANSM;
  logic                  HWRITEM;
  logic [2:0]            HSIZEM;
  logic [2:0]            HBURSTM;
  logic [3:0]            HPROTM;
  logic                  HMASTLOCKM;
  logic                  req_port;
  logic                  addr_in_phase;
  logic                  data_in_phase;
  logic                  HREADYOUTM;
  logic                  HRESPM;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, addr_in_phase, data_in_phase,
           HREADYOUTM, HRESPM,
    output HREADYOUTS, HRESPS, HADDRM, HTRANSM, HWRITEM, HSIZEM,
           HBURSTM, HPROTM, HMASTLOCKM, req_port
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, addr_in_phase, data_in_phase,
           HREADYOUTM, HRESPM,
    input  HREADYOUTS, HRESPS, HADDRM, HTRANSM, HWRITEM, HSIZEM,
           HBURSTM, HPROTM, HMASTLOCKM, req_port
  );
endinterface

// File: rtl/ahb_mtx_input_stage.sv
// ahb_mtx_input_stage
//   Per-master input stage of the AHB bus matrix. An address phase that the
//   matrix cannot take immediately is parked in a holding register and the
//   master is stalled until an output stage samples it; the parked transfer
//   is then replayed exactly once.
//   Ports:
//     HCLK   - system clock, rising edge
//     HRESET - synchronous active-high reset
//     bus    - ahb_mtx_input_stage_if.slave (S-side master bus, M-side
//              output-stage bus, req_port and grant/data-phase feedback)
//   SEQ_CONVERT=1 replays a parked SEQ as NONSEQ/INCR, since the output
//   stage may have served other masters in between and the burst context
//   is lost.
module ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit SEQ_CONVERT = 1'b1
) (
  input logic HCLK,
  input logic HRESET,
  ahb_mtx_input_stage_if.slave bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic                  pend_tran;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic [3:0]            hold_prot;
  logic                  hold_lock;

  logic trans_valid;
  logic release_hold;
  logic seq_replay;

  assign trans_valid  = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
  // The output stage gates HREADYOUTM to this port, so grant plus ready
  // means the parked address has actually been taken.
  assign release_hold = bus.addr_in_phase & bus.HREADYOUTM;
  assign seq_replay   = SEQ_CONVERT && (hold_trans == TRANS_SEQ);

  // While pending, HREADYOUTS is low so the master cannot issue a new
  // valid transfer; capture is therefore only considered when idle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_tran  <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= TRANS_IDLE;
      hold_write <= 1'b0;
      hold_size  <= 3'b000;
      hold_burst <= 3'b000;
      hold_prot  <= 4'b0000;
      hold_lock  <= 1'b0;
    end else if (pend_tran) begin
      if (release_hold) begin
        pend_tran <= 1'b0;
      end
    end else if (trans_valid && !bus.addr_in_phase) begin
      pend_tran  <= 1'b1;
      hold_addr  <= bus.HADDRS;
      hold_trans <= bus.HTRANSS;
      hold_write <= bus.HWRITES;
      hold_size  <= bus.HSIZES;
      hold_burst <= bus.HBURSTS;
      hold_prot  <= bus.HPROTS;
      hold_lock  <= bus.HMASTLOCKS;
    end
  end

  logic [ADDR_WIDTH-1:0] addr_m;
  logic [1:0]            trans_m;
  logic                  write_m;
  logic [2:0]            size_m;
  logic [2:0]            burst_m;
  logic [3:0]            prot_m;
  logic                  lock_m;

  always_comb begin
    addr_m  = bus.HADDRS;
    trans_m = (bus.HSELS & bus.HREADYS) ? bus.HTRANSS : TRANS_IDLE;
    write_m = bus.HWRITES;
    size_m  = bus.HSIZES;
    burst_m = bus.HBURSTS;
    prot_m  = bus.HPROTS;
    lock_m  = bus.HMASTLOCKS;
    if (pend_tran) begin
      addr_m  = hold_addr;
      trans_m = seq_replay ? TRANS_NONSEQ : hold_trans;
      write_m = hold_write;
      size_m  = hold_size;
      burst_m = seq_replay ? BURST_INCR : hold_burst;
      prot_m  = hold_prot;
      lock_m  = hold_lock;
    end
  end

  assign bus.HADDRM     = addr_m;
  assign bus.HTRANSM    = trans_m;
  assign bus.HWRITEM    = write_m;
  assign bus.HSIZEM     = size_m;
  assign bus.HBURSTM    = burst_m;
  assign bus.HPROTM     = prot_m;
  assign bus.HMASTLOCKM = lock_m;

  // A locked master keeps requesting through IDLE cycles so the output
  // arbiter does not hand the port to someone else mid-sequence.
  assign bus.req_port   = pend_tran | trans_valid | (bus.HSELS & bus.HMASTLOCKS);

  assign bus.HREADYOUTS = pend_tran ? 1'b0 :
                          (bus.data_in_phase ? bus.HREADYOUTM : 1'b1);
  assign bus.HRESPS     = bus.data_in_phase ? bus.HRESPM : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
module tb_ahb_mtx_input_stage;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic        hsels, hwrites, hlock, hreadys;
  logic [31:0] haddrs;
  logic [1:0]  htranss;
  logic [2:0]  hsizes, hbursts;
  logic [3:0]  hprots;
  logic        aip, dip, rdym, respm;

  ahb_mtx_input_stage_if #(.ADDR_WIDTH(32)) bus_c ();
  ahb_mtx_input_stage_if #(.ADDR_WIDTH(32)) bus_r ();

  assign bus_c.HSELS = hsels;          assign bus_r.HSELS = hsels;
  assign bus_c.HADDRS = haddrs;        assign bus_r.HADDRS = haddrs;
  assign bus_c.HTRANSS = htranss;      assign bus_r.HTRANSS = htranss;
  assign bus_c.HWRITES = hwrites;      assign bus_r.HWRITES = hwrites;
  assign bus_c.HSIZES = hsizes;        assign bus_r.HSIZES = hsizes;
  assign bus_c.HBURSTS = hbursts;      assign bus_r.HBURSTS = hbursts;
  assign bus_c.HPROTS = hprots;        assign bus_r.HPROTS = hprots;
  assign bus_c.HMASTLOCKS = hlock;     assign bus_r.HMASTLOCKS = hlock;
  assign bus_c.HREADYS = hreadys;      assign bus_r.HREADYS = hreadys;
  assign bus_c.addr_in_phase = aip;    assign bus_r.addr_in_phase = aip;
  assign bus_c.data_in_phase = dip;    assign bus_r.data_in_phase = dip;
  assign bus_c.HREADYOUTM = rdym;      assign bus_r.HREADYOUTM = rdym;
  assign bus_c.HRESPM = respm;         assign bus_r.HRESPM = respm;

  ahb_mtx_input_stage #(.ADDR_WIDTH(32), .SEQ_CONVERT(1'b1)) u_dut_conv (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_c)
  );
  ahb_mtx_input_stage #(.ADDR_WIDTH(32), .SEQ_CONVERT(1'b0)) u_dut_raw (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_r)
  );

  logic [48:0] out_c, out_r;
  assign out_c = {bus_c.HREADYOUTS, bus_c.HRESPS, bus_c.req_port, bus_c.HADDRM,
                  bus_c.HTRANSM, bus_c.HWRITEM, bus_c.HSIZEM, bus_c.HBURSTM,
                  bus_c.HPROTM, bus_c.HMASTLOCKM};
  assign out_r = {bus_r.HREADYOUTS, bus_r.HRESPS, bus_r.req_port, bus_r.HADDRM,
                  bus_r.HTRANSM, bus_r.HWRITEM, bus_r.HSIZEM, bus_r.HBURSTM,
                  bus_r.HPROTM, bus_r.HMASTLOCKM};

  // Reference model: the parked transfer lives in a queue (empty = nothing held).
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  xfer_t held_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_captured = 0;
  int    n_released = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_readyout();
    if (held_q.size() != 0) return 1'b0;
    return dip ? rdym : 1'b1;
  endfunction

  function automatic logic [48:0] model_out(input bit seq_conv);
    xfer_t x;
    logic  rdy_o, resp_o, req_o;
    rdy_o  = model_readyout();
    resp_o = dip ? respm : 1'b0;
    req_o  = (held_q.size() != 0) || (hsels && hreadys && htranss[1]) || (hsels && hlock);
    if (held_q.size() != 0) begin
      x = held_q[0];
      if (seq_conv && x.trans == 2'b11) begin
        x.trans = 2'b10;
        x.burst = 3'b001;
      end
    end else begin
      x.addr  = haddrs;
      x.trans = (hsels && hreadys) ? htranss : 2'b00;
      x.write = hwrites;
      x.size  = hsizes;
      x.burst = hbursts;
      x.prot  = hprots;
      x.lock  = hlock;
    end
    return {rdy_o, resp_o, req_o, x};
  endfunction

  task automatic model_update();
    xfer_t x;
    if (HRESET) begin
      held_q.delete();
    end else if (held_q.size() != 0) begin
      if (aip && rdym) begin
        x = held_q.pop_front();
        n_released++;
      end
    end else if (hsels && hreadys && htranss[1] && !aip) begin
      x = '{addr: haddrs, trans: htranss, write: hwrites, size: hsizes,
            burst: hbursts, prot: hprots, lock: hlock};
      held_q.push_back(x);
      n_captured++;
    end
  endtask

  // Called at the falling edge: compare both DUTs, then advance the model
  // across the coming rising edge and set up for the next cycle.
  task automatic advance();
    chk("model_conv", {15'd0, out_c}, {15'd0, model_out(1'b1)});
    chk("model_raw",  {15'd0, out_r}, {15'd0, model_out(1'b0)});
    model_update();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    hreadys = model_readyout();
    #4;
  endtask

  task automatic set_idle();
    hsels = 0; haddrs = '0; htranss = 2'b00; hwrites = 0; hsizes = 3'd0;
    hbursts = 3'd0; hprots = 4'd0; hlock = 0;
    aip = 0; dip = 0; rdym = 1; respm = 0;
  endtask

  task automatic set_xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                          input logic [2:0] b);
    hsels = 1; haddrs = a; htranss = t; hwrites = w; hsizes = 3'd2;
    hbursts = b; hprots = 4'b0011; hlock = 0;
  endtask

  initial begin
    set_idle();
    hreadys = 1;
    HRESET = 1;
    @(posedge HCLK); #1;
    settle();
    chk("rst_readyout", bus_c.HREADYOUTS, 1'b1);
    chk("rst_resp",     bus_c.HRESPS,     1'b0);
    chk("rst_req",      bus_c.req_port,   1'b0);
    chk("rst_htransm",  bus_c.HTRANSM,    2'b00);
    advance();
    HRESET = 0;

    // Direct grant: zero latency, nothing held
    set_xfer(32'h2000_0000, 2'b10, 1'b0, 3'b000);
    aip = 1;
    settle();
    chk("grant_htransm", bus_c.HTRANSM, 2'b10);
    chk("grant_haddrm",  bus_c.HADDRM,  32'h2000_0000);
    chk("grant_req",     bus_c.req_port, 1'b1);
    advance();
    set_idle(); dip = 1; rdym = 1;
    settle();
    chk("grant_dphase_ready", bus_c.HREADYOUTS, 1'b1);
    chk("grant_no_pend_req",  bus_c.req_port,   1'b0);
    advance();

    // Held transfer: 3 stalled cycles, replayed address stable
    set_idle();
    set_xfer(32'h4000_0010, 2'b10, 1'b1, 3'b000);
    settle();
    chk("hold_addr_cycle_ready", bus_c.HREADYOUTS, 1'b1);
    advance();
    for (int i = 0; i < 3; i++) begin
      aip = (i == 2); rdym = 1;
      settle();
      chk("hold_readyout", bus_c.HREADYOUTS, 1'b0);
      chk("hold_haddrm",   bus_c.HADDRM,     32'h4000_0010);
      chk("hold_htransm",  bus_c.HTRANSM,    2'b10);
      chk("hold_hwritem",  bus_c.HWRITEM,    1'b1);
      chk("hold_req",      bus_c.req_port,   1'b1);
      advance();
    end
    set_idle();
    settle();
    chk("hold_released_ready", bus_c.HREADYOUTS, 1'b1);
    chk("hold_released_req",   bus_c.req_port,   1'b0);
    advance();

    // SEQ conversion: INCR4 beat 2 held two cycles
    set_xfer(32'h0000_0104, 2'b11, 1'b0, 3'b011);
    settle();
    advance();
    for (int i = 0; i < 2; i++) begin
      aip = (i == 1); rdym = 1;
      settle();
      chk("seqconv_htransm", bus_c.HTRANSM, 2'b10);
      chk("seqconv_hburstm", bus_c.HBURSTM, 3'b001);
      chk("seqraw_htransm",  bus_r.HTRANSM, 2'b11);
      chk("seqraw_hburstm",  bus_r.HBURSTM, 3'b011);
      chk("seq_haddrm",      bus_c.HADDRM,  32'h0000_0104);
      advance();
    end
    set_idle();
    settle();
    advance();

    // Two-cycle ERROR; master cancels with IDLE in the second cycle
    set_xfer(32'h5000_0000, 2'b10, 1'b0, 3'b000);
    dip = 1; respm = 1; rdym = 0;
    settle();
    chk("err1_resp",  bus_c.HRESPS,     1'b1);
    chk("err1_ready", bus_c.HREADYOUTS, 1'b0);
    advance();
    htranss = 2'b00; rdym = 1;
    settle();
    chk("err2_resp",  bus_c.HRESPS,     1'b1);
    chk("err2_ready", bus_c.HREADYOUTS, 1'b1);
    advance();
    set_idle();
    settle();
    chk("err_no_capture_req", bus_c.req_port, 1'b0);
    advance();

    // Reset while a transfer is parked
    set_xfer(32'h6000_0040, 2'b10, 1'b1, 3'b000);
    settle();
    advance();
    set_idle();
    HRESET = 1;
    settle();
    chk("rstpend_held_req", bus_c.req_port, 1'b1);
    advance();
    HRESET = 0;
    settle();
    chk("rstpend_req",     bus_c.req_port,   1'b0);
    chk("rstpend_ready",   bus_c.HREADYOUTS, 1'b1);
    chk("rstpend_htransm", bus_c.HTRANSM,    2'b00);
    advance();

    // Locked IDLE
    hsels = 1; hlock = 1; htranss = 2'b00;
    settle();
    chk("lock_req",   bus_c.req_port,   1'b1);
    chk("lock_ready", bus_c.HREADYOUTS, 1'b1);
    advance();
    set_idle();
    settle();
    chk("lock_no_capture", bus_c.req_port, 1'b0);
    advance();

    // Randomized traffic; HREADYS is the looped-back model ready
    for (int cyc = 0; cyc < 3000; cyc++) begin
      HRESET  = ($urandom_range(0, 199) == 0);
      hsels   = ($urandom_range(0, 3) != 0);
      haddrs  = $urandom;
      htranss = 2'($urandom_range(0, 3));
      hwrites = 1'($urandom);
      hsizes  = 3'($urandom);
      hbursts = 3'($urandom);
      hprots  = 4'($urandom);
      hlock   = ($urandom_range(0, 7) == 0);
      aip     = ($urandom_range(0, 2) == 0);
      dip     = 1'($urandom);
      rdym    = ($urandom_range(0, 3) != 0);
      respm   = ($urandom_range(0, 7) == 0);
      settle();
      advance();
    end
    HRESET = 0;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      aip = 1; rdym = 1;
      settle();
      advance();
    end
    chk("random_capture_activity", {63'd0, n_captured > 20}, 64'd1);
    chk("random_release_activity", {63'd0, n_released > 20}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
